// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the MEM stage of the CPU pipeline.
// Contents:
//   - bit positions inside the 4-bit EX/MEM control field
//   - width of the control field handed on to write-back
//   - the two-state type used by the memory-access FSM
//   - small helpers that decode the control field
package cpu_pipe_pkg;

  localparam int CTL_W        = 4;
  localparam int CTL_MEMREAD  = 0;
  localparam int CTL_MEMWRITE = 1;
  localparam int CTL_REGWRITE = 2;
  localparam int CTL_MEMTOREG = 3;

  localparam int WB_CTL_W     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Any load or store needs a data-memory transaction.
  function automatic logic is_mem_op(input logic [CTL_W-1:0] ctl);
    return ctl[CTL_MEMREAD] | ctl[CTL_MEMWRITE];
  endfunction

  // Write-back control: [0] RegWrite, [1] MemToReg.
  function automatic logic [WB_CTL_W-1:0] wb_ctl_of(input logic [CTL_W-1:0] ctl);
    return {ctl[CTL_MEMTOREG], ctl[CTL_REGWRITE]};
  endfunction

endpackage

// File: rtl/dmem_wait_timer.sv
// Counts the cycles a data-memory request has been outstanding.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   clear     - force the count back to zero (takes priority over enable)
//   enable    - advance the count by one this edge
//   expire    - count has reached TIMEOUT_CYCLES-1, i.e. the last allowed wait cycle
module dmem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_r;

  // Wait-cycle counter; it stops at LAST so it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {TW{1'b0}};
    end else if (clear) begin
      count_r <= {TW{1'b0}};
    end else if (enable && !expire) begin
      count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == LAST);

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage controller: turns the EX/MEM register fields into a req/ack
// data-memory transaction, stalls the front of the pipe while it is
// outstanding, gives up after TIMEOUT_CYCLES wait cycles, and drives a
// registered MEM/WB bundle.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   MEM_control_signal  - [0]MemRead [1]MemWrite [2]RegWrite [3]MemToReg
//   MEM_ALU_result      - address for loads/stores, result otherwise
//   MEM_read2           - store data
//   MEM_register_num    - destination register
//   stall               - combinational; 1 = EX/MEM and earlier hold
//   dmem_req/we/addr/wdata - registered request, stable while dmem_req
//   dmem_ack, dmem_rdata   - completion pulse and load data
//   WB_*                - registered write-back bundle
//   err_timeout         - one-cycle pulse when a request is abandoned
module mem_stage_access_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int REG_W          = 3,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CTL_W-1:0]    MEM_control_signal,
  input  logic [DATA_W-1:0]   MEM_ALU_result,
  input  logic [DATA_W-1:0]   MEM_read2,
  input  logic [REG_W-1:0]    MEM_register_num,
  output logic                stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_ack,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic [WB_CTL_W-1:0] WB_control_signal,
  output logic [DATA_W-1:0]   WB_mem_data,
  output logic [DATA_W-1:0]   WB_ALU_result,
  output logic [REG_W-1:0]    WB_register_num,
  output logic                err_timeout
);

  mem_state_t          state_r;
  logic                mem_op_s;
  logic                expire_s;
  logic                timer_clear_s;
  logic                timer_en_s;
  // The instruction being serviced is captured at request time so the
  // write-back bundle does not depend on upstream holding its value.
  logic [WB_CTL_W-1:0] hold_wb_ctl_r;
  logic [DATA_W-1:0]   hold_alu_r;
  logic [REG_W-1:0]    hold_reg_r;

  assign mem_op_s      = is_mem_op(MEM_control_signal);
  assign timer_clear_s = (state_r == IDLE);
  assign timer_en_s    = (state_r == WAIT) && !dmem_ack;

  dmem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .expire (expire_s)
  );

  // Stall: hold upstream while a request is being launched or is pending;
  // release in the ack cycle or the final time-out cycle so upstream
  // advances on the same edge the transaction retires.
  always_comb begin
    stall = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else begin
      case (state_r)
        IDLE:    stall = mem_op_s;
        WAIT:    stall = !dmem_ack && !expire_s;
        default: stall = 1'b0;
      endcase
    end
  end

  // Memory-access FSM with registered request and write-back outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= IDLE;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= {ADDR_W{1'b0}};
      dmem_wdata        <= {DATA_W{1'b0}};
      WB_control_signal <= {WB_CTL_W{1'b0}};
      WB_mem_data       <= {DATA_W{1'b0}};
      WB_ALU_result     <= {DATA_W{1'b0}};
      WB_register_num   <= {REG_W{1'b0}};
      err_timeout       <= 1'b0;
      hold_wb_ctl_r     <= {WB_CTL_W{1'b0}};
      hold_alu_r        <= {DATA_W{1'b0}};
      hold_reg_r        <= {REG_W{1'b0}};
    end else begin
      err_timeout <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mem_op_s) begin
            // Both MemRead and MemWrite set: treated as a write.
            dmem_req          <= 1'b1;
            dmem_we           <= MEM_control_signal[CTL_MEMWRITE];
            dmem_addr         <= MEM_ALU_result[ADDR_W-1:0];
            dmem_wdata        <= MEM_read2;
            hold_wb_ctl_r     <= wb_ctl_of(MEM_control_signal);
            hold_alu_r        <= MEM_ALU_result;
            hold_reg_r        <= MEM_register_num;
            WB_control_signal <= {WB_CTL_W{1'b0}};
            WB_mem_data       <= {DATA_W{1'b0}};
            WB_ALU_result     <= {DATA_W{1'b0}};
            WB_register_num   <= {REG_W{1'b0}};
            state_r           <= WAIT;
          end else begin
            WB_control_signal <= wb_ctl_of(MEM_control_signal);
            WB_mem_data       <= {DATA_W{1'b0}};
            WB_ALU_result     <= MEM_ALU_result;
            WB_register_num   <= MEM_register_num;
            state_r           <= IDLE;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            // Ack beats a coincident time-out.
            dmem_req          <= 1'b0;
            WB_control_signal <= hold_wb_ctl_r;
            WB_mem_data       <= dmem_we ? {DATA_W{1'b0}} : dmem_rdata;
            WB_ALU_result     <= hold_alu_r;
            WB_register_num   <= hold_reg_r;
            state_r           <= IDLE;
          end else if (expire_s) begin
            dmem_req          <= 1'b0;
            err_timeout       <= 1'b1;
            WB_control_signal <= {WB_CTL_W{1'b0}};
            WB_mem_data       <= {DATA_W{1'b0}};
            WB_ALU_result     <= {DATA_W{1'b0}};
            WB_register_num   <= {REG_W{1'b0}};
            state_r           <= IDLE;
          end else begin
            WB_control_signal <= {WB_CTL_W{1'b0}};
            WB_mem_data       <= {DATA_W{1'b0}};
            WB_ALU_result     <= {DATA_W{1'b0}};
            WB_register_num   <= {REG_W{1'b0}};
            state_r           <= WAIT;
          end
        end
        default: begin
          dmem_req          <= 1'b0;
          WB_control_signal <= {WB_CTL_W{1'b0}};
          WB_mem_data       <= {DATA_W{1'b0}};
          WB_ALU_result     <= {DATA_W{1'b0}};
          WB_register_num   <= {REG_W{1'b0}};
          state_r           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
module tb_mem_stage_access_ctrl;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] MEM_control_signal;
  logic [7:0] MEM_ALU_result;
  logic [7:0] MEM_read2;
  logic [2:0] MEM_register_num;
  logic       stall;
  logic       dmem_req;
  logic       dmem_we;
  logic [7:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic       dmem_ack;
  logic [7:0] dmem_rdata;
  logic [1:0] WB_control_signal;
  logic [7:0] WB_mem_data;
  logic [7:0] WB_ALU_result;
  logic [2:0] WB_register_num;
  logic       err_timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] ctl;
    logic [7:0] mem_data;
    logic [7:0] alu;
    logic [2:0] regn;
  } wb_exp_t;

  typedef struct {
    logic [3:0] ctl;
    logic [7:0] res;
    logic [7:0] r2;
    logic [2:0] regn;
    logic       ack;
    logic [1:0] exp_ctl;
  } vec_t;

  wb_exp_t sb_q[$];
  vec_t    vecs[6];

  mem_stage_access_ctrl #(
    .DATA_W(8), .ADDR_W(8), .REG_W(3), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .MEM_control_signal (MEM_control_signal),
    .MEM_ALU_result     (MEM_ALU_result),
    .MEM_read2          (MEM_read2),
    .MEM_register_num   (MEM_register_num),
    .stall              (stall),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .WB_control_signal  (WB_control_signal),
    .WB_mem_data        (WB_mem_data),
    .WB_ALU_result      (WB_ALU_result),
    .WB_register_num    (WB_register_num),
    .err_timeout        (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_wb_pop();
    wb_exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow: got empty queue, want an entry (t=%0t)", $time);
    end else begin
      e = sb_q.pop_front();
      chk("wb_ctl",      {30'd0, WB_control_signal}, {30'd0, e.ctl});
      chk("wb_mem_data", {24'd0, WB_mem_data},       {24'd0, e.mem_data});
      chk("wb_alu",      {24'd0, WB_ALU_result},     {24'd0, e.alu});
      chk("wb_reg",      {29'd0, WB_register_num},   {29'd0, e.regn});
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_req"},   {31'd0, dmem_req},          32'd0);
    chk({name, "_stall"}, {31'd0, stall},             32'd0);
    chk({name, "_addr"},  {24'd0, dmem_addr},         32'd0);
    chk({name, "_wdata"}, {24'd0, dmem_wdata},        32'd0);
    chk({name, "_wbctl"}, {30'd0, WB_control_signal}, 32'd0);
    chk({name, "_wbalu"}, {24'd0, WB_ALU_result},     32'd0);
    chk({name, "_wbreg"}, {29'd0, WB_register_num},   32'd0);
    chk({name, "_err"},   {31'd0, err_timeout},       32'd0);
  endtask

  // One load/store: ack_at = wait-cycle index of the ack (0 = first req cycle),
  // or a value >= TO for no ack at all.
  task automatic mem_txn(input logic [3:0] ctl, input logic [7:0] res, input logic [7:0] r2,
                         input logic [2:0] regn, input int ack_at, input logic [7:0] rdata);
    int      stall_cnt;
    int      req_cnt;
    bit      done;
    logic    is_wr;
    wb_exp_t e;
    is_wr = ctl[1];
    stall_cnt = 0;
    req_cnt = 0;
    done = 1'b0;
    @(negedge clk);
    MEM_control_signal = ctl;
    MEM_ALU_result = res;
    MEM_read2 = r2;
    MEM_register_num = regn;
    #1;
    chk("idle_stall", {31'd0, stall}, 32'd1);
    chk("idle_req",   {31'd0, dmem_req}, 32'd0);
    if (stall) stall_cnt++;
    for (int k = 0; k < TO && !done; k++) begin
      @(negedge clk);
      chk("req_high",   {31'd0, dmem_req}, 32'd1);
      if (dmem_req) req_cnt++;
      chk("req_we",     {31'd0, dmem_we}, {31'd0, is_wr});
      chk("req_addr",   {24'd0, dmem_addr}, {24'd0, res});
      chk("req_wdata",  {24'd0, dmem_wdata}, {24'd0, r2});
      chk("wait_wbctl", {30'd0, WB_control_signal}, 32'd0);
      chk("wait_err",   {31'd0, err_timeout}, 32'd0);
      if (k == ack_at) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        e.ctl = {ctl[3], ctl[2]};
        e.mem_data = is_wr ? 8'h00 : rdata;
        e.alu = res;
        e.regn = regn;
        sb_q.push_back(e);
        done = 1'b1;
        #1;
        chk("ack_stall", {31'd0, stall}, 32'd0);
      end else begin
        #1;
        chk("wait_stall", {31'd0, stall}, (k == TO - 1) ? 32'd0 : 32'd1);
        if (stall) stall_cnt++;
      end
    end
    @(negedge clk);
    chk("post_req", {31'd0, dmem_req}, 32'd0);
    if (done) begin
      check_wb_pop();
      chk("post_err",   {31'd0, err_timeout}, 32'd0);
      chk("stall_cnt",  stall_cnt, ack_at + 1);
      chk("req_cnt",    req_cnt, ack_at + 1);
    end else begin
      chk("to_err",     {31'd0, err_timeout}, 32'd1);
      chk("to_wbctl",   {30'd0, WB_control_signal}, 32'd0);
      chk("to_req_cnt", req_cnt, TO);
      chk("to_stall_cnt", stall_cnt, TO);
    end
    dmem_ack = 1'b0;
    MEM_control_signal = 4'b0000;
    MEM_ALU_result = 8'h00;
    MEM_read2 = 8'h00;
    MEM_register_num = 3'd0;
    #1;
    chk("post_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("err_pulse_end", {31'd0, err_timeout}, 32'd0);
    chk("idle_req2",     {31'd0, dmem_req}, 32'd0);
  endtask

  initial begin
    wb_exp_t e;
    vecs[0] = '{ctl: 4'b0100, res: 8'h3C, r2: 8'h00, regn: 3'd5, ack: 1'b0, exp_ctl: 2'b01};
    vecs[1] = '{ctl: 4'b0000, res: 8'h11, r2: 8'h22, regn: 3'd2, ack: 1'b0, exp_ctl: 2'b00};
    vecs[2] = '{ctl: 4'b1100, res: 8'hA5, r2: 8'h5A, regn: 3'd7, ack: 1'b0, exp_ctl: 2'b11};
    vecs[3] = '{ctl: 4'b1000, res: 8'hFF, r2: 8'h01, regn: 3'd0, ack: 1'b0, exp_ctl: 2'b10};
    vecs[4] = '{ctl: 4'b0100, res: 8'h00, r2: 8'hFF, regn: 3'd3, ack: 1'b1, exp_ctl: 2'b01};
    vecs[5] = '{ctl: 4'b0100, res: 8'h81, r2: 8'h00, regn: 3'd6, ack: 1'b0, exp_ctl: 2'b01};

    rst = 1'b1;
    MEM_control_signal = 4'b0001;
    MEM_ALU_result = 8'h55;
    MEM_read2 = 8'h66;
    MEM_register_num = 3'd1;
    dmem_ack = 1'b0;
    dmem_rdata = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    MEM_control_signal = 4'b0000;
    rst = 1'b0;

    // Non-memory ops, one per cycle; an ack while idle must be ignored.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_wb_pop();
        chk("plain_req", {31'd0, dmem_req}, 32'd0);
      end
      MEM_control_signal = vecs[i].ctl;
      MEM_ALU_result = vecs[i].res;
      MEM_read2 = vecs[i].r2;
      MEM_register_num = vecs[i].regn;
      dmem_ack = vecs[i].ack;
      dmem_rdata = 8'hEE;
      #1;
      chk("plain_stall", {31'd0, stall}, 32'd0);
      e.ctl = vecs[i].exp_ctl;
      e.mem_data = 8'h00;
      e.alu = vecs[i].res;
      e.regn = vecs[i].regn;
      sb_q.push_back(e);
    end
    @(negedge clk);
    check_wb_pop();
    chk("plain_req_end", {31'd0, dmem_req}, 32'd0);
    dmem_ack = 1'b0;
    MEM_control_signal = 4'b0000;

    mem_txn(4'b1101, 8'h20, 8'h00, 3'd4, 3, 8'hA5);       // load, ack 3 cycles after req
    mem_txn(4'b0010, 8'h10, 8'h77, 3'd1, 1, 8'hCC);       // store, ack after 1 cycle
    mem_txn(4'b0101, 8'h44, 8'h00, 3'd2, TO + 5, 8'h00);  // load, never acked
    mem_txn(4'b0111, 8'h30, 8'h99, 3'd6, TO - 1, 8'h3E);  // write+read bits, ack on last cycle
    mem_txn(4'b1101, 8'hF0, 8'h00, 3'd7, 0, 8'h5C);       // load, ack in first wait cycle

    // Reset during the second WAIT cycle.
    @(negedge clk);
    MEM_control_signal = 4'b1101;
    MEM_ALU_result = 8'h20;
    MEM_register_num = 3'd3;
    @(negedge clk);
    chk("rw_req1", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    chk("rw_req2", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midwait_rst");
    @(negedge clk);
    MEM_control_signal = 4'b0000;
    MEM_ALU_result = 8'h00;
    MEM_register_num = 3'd0;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_err", {31'd0, err_timeout}, 32'd0);
    chk("after_rst_req", {31'd0, dmem_req}, 32'd0);
    mem_txn(4'b1101, 8'h21, 8'h00, 3'd2, 2, 8'h6B);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
